shift_add_mult_ctrl: RTL

- Sequential unsigned shift-add multiplier for the ALU.
- Contains the FSM that sits directly upstream of the 4-bit down-counter:
  - drives the counter's load and count-enable inputs;
  - consumes its terminal-count flag to end iteration.
- Contains the accumulator/multiplier shift datapath.
- Handshake: start in; busy/done and the held product out.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 27 ++
 rtl/shift_add_mult_ctrl_down_counter_4b.sv | 39 +++
 rtl/shift_add_mult_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// shift_add_mult_ctrl_pkg
//
// Shared definitions for the sequential shift-add multiplier:
//   - state_t      : FSM state encoding (IDLE, TEST, ADD, SHIFT, DONE)
//   - DEFAULT_WIDTH: default operand width in bits
//   - CNT_W        : width of the iteration down-counter
// ----------------------------------------------------------------------------
package shift_add_mult_ctrl_pkg;

    // Default operand width. Legal range is 2..8.
    localparam int DEFAULT_WIDTH = 4;

    // The iteration counter is 4 bits wide, so its load value must fit in it.
    localparam int CNT_W = 4;

    // FSM state encoding. Three bits leave three unused codes; the FSM
    // returns any of those to IDLE on the next edge.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TEST  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : shift_add_mult_ctrl_pkg

// File: rtl/shift_add_mult_ctrl_down_counter_4b.sv
// ----------------------------------------------------------------------------
// down_counter_4b
//
// 4-bit loadable down-counter used as the multiplier's iteration counter.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset (clears the count)
//   i_ld     in   load i_in into the count (has priority over i_cnt)
//   i_cnt    in   decrement the count by one
//   i_in     in   [3:0] load value
//   o_tcount out  terminal count: high while the count is zero
//
// The count does not wrap: a decrement request at zero leaves it at zero.
// ----------------------------------------------------------------------------
module down_counter_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ld,
    input  logic       i_cnt,
    input  logic [3:0] i_in,
    output logic       o_tcount
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_ld) begin
            r_count <= i_in;
        end else if (i_cnt && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_tcount = (r_count == 4'd0);

endmodule : down_counter_4b

// File: rtl/shift_add_mult_ctrl.sv
// ----------------------------------------------------------------------------
// shift_add_mult_ctrl
//
// Sequential unsigned shift-add multiplier. One accepted start produces a
// 2*WIDTH-bit product after WIDTH iterations of TEST -> ADD -> SHIFT.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (any state)
//   start      in   request; only sampled in IDLE
//   a          in   [WIDTH-1:0] multiplicand, captured on the accepted start
//   b          in   [WIDTH-1:0] multiplier, captured on the accepted start
//   product    out  [2*WIDTH-1:0] result; valid in the done cycle, held after
//   busy       out  high in every TEST, ADD and SHIFT cycle
//   done       out  one-cycle pulse in the DONE state
//   state_dbg  out  [2:0] current FSM state (state_t encoding)
//
// Handshake: start is a level request that is accepted on any rising edge
// where the FSM is in IDLE and start is high; there is no ready/ack, a start
// seen in any other state is dropped. done marks the one cycle in which
// product first shows the new result.
//
// Datapath registers: M (multiplicand), A (accumulator), Q (multiplier / low
// product half), C (carry out of the add, shifted into A on the next SHIFT).
// ----------------------------------------------------------------------------
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg
);

    // Iteration count loaded into the counter on an accepted start.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WIDTH);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic                 r_c;
    logic [2*WIDTH-1:0]   r_product;

    // ------------------------------------------------------------------
    // FSM outputs / counter control
    // ------------------------------------------------------------------
    logic                 w_ld;
    logic                 w_cnt;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_tcount;

    // (WIDTH+1)-bit sum; the top bit becomes the carry C.
    logic [WIDTH:0]       w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, r_m};

    // ------------------------------------------------------------------
    // Iteration counter
    // ------------------------------------------------------------------
    down_counter_4b u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_ld     (w_ld),
        .i_cnt    (w_cnt),
        .i_in     (LOAD_VAL),
        .o_tcount (w_tcount)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs. ld is only raised in IDLE and cnt only
    // in SHIFT, so the two are mutually exclusive by construction.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = ST_IDLE;
        w_ld         = 1'b0;
        w_cnt        = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_ld         = 1'b1;
                    w_next_state = ST_TEST;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_TEST: begin
                w_busy       = 1'b1;
                // Terminal count means all WIDTH shifts have been done.
                w_next_state = w_tcount ? ST_DONE : ST_ADD;
            end

            ST_ADD: begin
                w_busy       = 1'b1;
                w_next_state = ST_SHIFT;
            end

            ST_SHIFT: begin
                w_busy       = 1'b1;
                w_cnt        = 1'b1;
                w_next_state = ST_TEST;
            end

            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_c       <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m <= a;
                        r_q <= b;
                        r_a <= '0;
                        r_c <= 1'b0;
                    end
                end

                ST_ADD: begin
                    // Add the multiplicand only when the current multiplier
                    // bit is set; otherwise A and C hold.
                    if (r_q[0]) begin
                        {r_c, r_a} <= w_sum;
                    end
                end

                ST_SHIFT: begin
                    // Logical right shift of {C,A,Q}: the carry drops into
                    // the top of A, A's LSB into the top of Q, C clears.
                    {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[WIDTH-1:1]};
                end

                ST_DONE: begin
                    r_product <= {r_a, r_q};
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The product register only updates at the edge that ends
    // DONE, so during the DONE cycle itself the fresh {A,Q} is forwarded;
    // A and Q are stable in DONE, so the value does not change at that edge.
    // ------------------------------------------------------------------
    assign product   = (r_state == ST_DONE) ? {r_a, r_q} : r_product;
    assign busy      = w_busy;
    assign done      = w_done;
    assign state_dbg = r_state;

endmodule : shift_add_mult_ctrl
